writeback: RTL and testbench
============================

# writeback

Y86-64 SEQ/PIPE writeback stage, directly downstream of the memory stage. Captures the memory stage's results (`valE`, `valM`, destination IDs, status) into a W pipeline register. Commits them into the 15-entry register file and serves the decode-stage read ports. Tracks processor status in a RUN/HALT/ERROR state machine and counts retired instructions.

## Interface
Parameters:
- `NREG`, 15: number of architectural registers (IDs 0..14; ID 15 = RNONE).
- `CNT_W`, 64: width of retired-instruction counter.

Ports:
- `clock`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `m_valid`  in  1  memory stage holds a real instruction.
- `m_stat`  in  3  status from memory stage (AOK=1, HLT=2, ADR=3, INS=4).
- `m_icode`  in  4  instruction code.
- `m_valE`  in  64  ALU result.
- `m_valM`  in  64  memory read result.
- `m_dstE`  in  4  destination for `valE`.
- `m_dstM`  in  4  destination for `valM`.
- `w_stall`  in  1  hold W register.
- `w_bubble`  in  1  load bubble into W register.
- `srcA`, `srcB`  in  4 each  decode read addresses.
- `valA`, `valB`  out  64 each  combinational read data.
- `W_icode`, `W_dstE`, `W_dstM`  out  4 each  W register contents.
- `W_valE`, `W_valM`  out  64 each  W register contents.
- `W_stat`  out  3  W register status.
- `stat_out`  out  3  architectural processor status.
- `halted`  out  1  high in HALT or ERROR.
- `retired`  out  `CNT_W`  retired-instruction count.

## Operation
- **Reset (async):**
  - W register loads the bubble: `W_icode`=1 (nop), `W_dstE`=`W_dstM`=15, `W_valE`=`W_valM`=0, `W_stat`=AOK, internal `W_valid`=0.
  - All registers clear to 0.
  - State RUN, `stat_out`=AOK, `halted`=0, `retired`=0.
- **W register update, per rising edge, in RUN:**
  - `w_stall`=1: hold.
  - else `w_bubble`=1: load bubble.
  - else: load `m_*`.
  - Stall wins over bubble.
- **Register write:**
  - Happens each rising edge in RUN when `W_valid`=1 and `W_stat`=AOK.
  - Write `W_valE` to `W_dstE` and `W_valM` to `W_dstM`.
  - Destination 15 means no write.
  - If `W_dstE`==`W_dstM`≠15, `W_valM` is written (popq %rsp rule).
- **Reads:**
  - `valA`/`valB` = register contents, combinational; 0 for ID 15.
  - No internal bypass; forwarding belongs to decode.
- **State machine (transitions evaluated on edge from W contents):**
  - RUN → HALT when `W_valid` and `W_stat`=HLT.
  - RUN → ERROR when `W_valid` and `W_stat` ∈ {ADR, INS}.
  - The instruction causing the transition performs no register write.
  - HALT and ERROR are absorbing: W register frozen, no writes, counter frozen, `m_*`/`w_stall`/`w_bubble` ignored. Only `reset` exits.
  - `stat_out`: AOK in RUN; HLT in HALT; the offending `W_stat` (latched) in ERROR.
- **Retired count:** +1 per edge in RUN where `W_valid`=1 and `W_stat`=AOK. Wraps modulo 2^`CNT_W`.
- **Invalid stat:** a `W_stat` value of 0 or 5..7 with `W_valid`=1 is treated as INS.

## Timing
- Instruction on `m_*` at edge N is in W after N.
- Its register write and counter increment occur at edge N+1.
- New value is visible on `valA`/`valB` after edge N+1, same cycle.
- `stat_out`/`halted` change at the edge where the faulting instruction is in W (N+1).
- Reset is asynchronous assert; deassert is synchronized externally. Reset mid-cycle discards any pending write.

## Structure
- Shared package `y86_pkg`:
  - stat codes `STAT_AOK/HLT/ADR/INS`;
  - icodes (`I_NOP`=1, `I_HALT`=0, `I_RRMOVQ`=2, `I_IRMOVQ`=3, `I_MRMOVQ`=5, `I_OPQ`=6, `I_CALL`=8, `I_RET`=9, `I_PUSHQ`=0xA, `I_POPQ`=0xB);
  - `RNONE`=15, `RRSP`=4;
  - state enum `WB_RUN/WB_HALT/WB_ERROR`.
- One sub-module `regfile`: two combinational read ports, two write ports with M-priority on collision, async reset clear.

## Test plan
- **irmovq write:** `m_valid`=1, `m_icode`=3, `m_dstE`=2, `m_valE`=0x1234, `m_dstM`=15 → after 2 edges `srcA`=2 gives `valA`=0x1234, `retired`=1.
- **popq %rsp collision:** `m_dstE`=4, `m_valE`=0x100, `m_dstM`=4, `m_valM`=0xBEEF → R4=0xBEEF.
- **Stall/bubble:** stall with bubble held 3 cycles → W unchanged, no repeat writes, `retired` +1 only. Bubble alone → `W_icode`=1, no write, count unchanged.
- **Halt:** `m_stat`=HLT, `m_dstE`=3, `m_valE`=7 → `halted`=1, `stat_out`=2, R3 unchanged. Subsequent AOK writes ignored, `retired` frozen.
- **Error:** `m_stat`=ADR → `stat_out`=3.
- **Async reset:** assert `reset` mid-cycle after writes → all registers, `retired`, and W immediately at reset values; `stat_out`=AOK.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants for the writeback slice.
// Holds the status codes, instruction codes, special register IDs,
// the writeback status state type, and a helper that maps any fault
// status onto the code reported in ERROR.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [1:0] {
    WB_RUN   = 2'd0,
    WB_HALT  = 2'd1,
    WB_ERROR = 2'd2
  } wb_state_e;

  // ADR is reported as-is; INS and every undefined code report as INS.
  function automatic logic [2:0] fault_stat(input logic [2:0] s);
    return (s == STAT_ADR) ? STAT_ADR : STAT_INS;
  endfunction

endpackage

// File: rtl/writeback_if.sv
// writeback_if: bundle between memory stage / decode and the writeback stage.
//   m_*            memory-stage results entering the W register
//   w_stall/bubble pipeline control for the W register
//   srcA/srcB      decode read addresses; valA/valB read data
//   W_*            W register contents
//   stat_out       architectural status; halted in HALT or ERROR
//   retired        retired-instruction count
// Modports: slave = writeback stage, master = its environment.
interface writeback_if #(parameter int CNT_W = 64) ();
  logic             m_valid;
  logic [2:0]       m_stat;
  logic [3:0]       m_icode;
  logic [63:0]      m_valE;
  logic [63:0]      m_valM;
  logic [3:0]       m_dstE;
  logic [3:0]       m_dstM;
  logic             w_stall;
  logic             w_bubble;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [63:0]      valA;
  logic [63:0]      valB;
  logic [3:0]       W_icode;
  logic [3:0]       W_dstE;
  logic [3:0]       W_dstM;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic [2:0]       W_stat;
  logic [2:0]       stat_out;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  m_valid, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
           w_stall, w_bubble, srcA, srcB,
    output valA, valB, W_icode, W_dstE, W_dstM, W_valE, W_valM, W_stat,
           stat_out, halted, retired
  );

  modport master (
    output m_valid, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
           w_stall, w_bubble, srcA, srcB,
    input  valA, valB, W_icode, W_dstE, W_dstM, W_valE, W_valM, W_stat,
           stat_out, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// regfile: NREG x 64-bit architectural register file.
// Ports: clock/reset (async, active-high clear), E and M write ports
// (we_*, dst_*, val_*), two combinational read ports (src_*/val_*).
// IDs at or above NREG (RNONE) never write and read as zero.
// When both write ports hit the same register, the M port wins.
module regfile #(
  parameter int NREG = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);

  logic [63:0] regs_q [NREG];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && dst_m == 4'(i))      regs_q[i] <= val_m;
        else if (we_e && dst_e == 4'(i)) regs_q[i] <= val_e;
      end
    end
  end

  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i)) val_a = regs_q[i];
      if (src_b == 4'(i)) val_b = regs_q[i];
    end
  end

endmodule

// File: rtl/writeback.sv
// writeback: Y86-64 writeback stage.
// Ports: clock, reset (async, active-high), wb (writeback_if.slave).
// Captures memory-stage results into the W register, commits AOK
// instructions into the register file, tracks RUN/HALT/ERROR status
// and counts retired instructions.
module writeback
  import y86_pkg::*;
#(
  parameter int NREG  = 15,
  parameter int CNT_W = 64
) (
  input  logic        clock,
  input  logic        reset,
  writeback_if.slave  wb
);

  wb_state_e        state_q, state_d;
  logic [2:0]       err_stat_q, err_stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             w_valid_q, w_valid_d;
  logic [2:0]       w_stat_q, w_stat_d;
  logic [3:0]       w_icode_q, w_icode_d;
  logic [63:0]      w_valE_q, w_valE_d;
  logic [63:0]      w_valM_q, w_valM_d;
  logic [3:0]       w_dstE_q, w_dstE_d;
  logic [3:0]       w_dstM_q, w_dstM_d;

  logic             commit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WB_RUN;
      err_stat_q <= STAT_AOK;
      retired_q  <= '0;
      w_valid_q  <= 1'b0;
      w_stat_q   <= STAT_AOK;
      w_icode_q  <= I_NOP;
      w_valE_q   <= '0;
      w_valM_q   <= '0;
      w_dstE_q   <= RNONE;
      w_dstM_q   <= RNONE;
    end else begin
      state_q    <= state_d;
      err_stat_q <= err_stat_d;
      retired_q  <= retired_d;
      w_valid_q  <= w_valid_d;
      w_stat_q   <= w_stat_d;
      w_icode_q  <= w_icode_d;
      w_valE_q   <= w_valE_d;
      w_valM_q   <= w_valM_d;
      w_dstE_q   <= w_dstE_d;
      w_dstM_q   <= w_dstM_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_stat_d = err_stat_q;
    retired_d  = retired_q;
    w_valid_d  = w_valid_q;
    w_stat_d   = w_stat_q;
    w_icode_d  = w_icode_q;
    w_valE_d   = w_valE_q;
    w_valM_d   = w_valM_q;
    w_dstE_d   = w_dstE_q;
    w_dstM_d   = w_dstM_q;
    commit     = 1'b0;

    if (state_q == WB_RUN) begin
      if (w_valid_q) begin
        if (w_stat_q == STAT_AOK) begin
          commit    = 1'b1;
          retired_d = retired_q + 1'b1;
        end else if (w_stat_q == STAT_HLT) begin
          state_d = WB_HALT;
        end else begin
          state_d    = WB_ERROR;
          err_stat_d = fault_stat(w_stat_q);
        end
      end

      if (wb.w_stall) begin
        // The held instruction has already been acted on this edge;
        // dropping its valid bit keeps it from writing or retiring twice.
        w_valid_d = 1'b0;
      end else if (wb.w_bubble) begin
        w_valid_d = 1'b0;
        w_stat_d  = STAT_AOK;
        w_icode_d = I_NOP;
        w_valE_d  = '0;
        w_valM_d  = '0;
        w_dstE_d  = RNONE;
        w_dstM_d  = RNONE;
      end else begin
        w_valid_d = wb.m_valid;
        w_stat_d  = wb.m_stat;
        w_icode_d = wb.m_icode;
        w_valE_d  = wb.m_valE;
        w_valM_d  = wb.m_valM;
        w_dstE_d  = wb.m_dstE;
        w_dstM_d  = wb.m_dstM;
      end
    end
  end

  regfile #(.NREG(NREG)) u_regfile (
    .clock (clock),
    .reset (reset),
    .we_e  (commit && (w_dstE_q != RNONE)),
    .dst_e (w_dstE_q),
    .val_e (w_valE_q),
    .we_m  (commit && (w_dstM_q != RNONE)),
    .dst_m (w_dstM_q),
    .val_m (w_valM_q),
    .src_a (wb.srcA),
    .src_b (wb.srcB),
    .val_a (wb.valA),
    .val_b (wb.valB)
  );

  always_comb begin
    unique case (state_q)
      WB_RUN:  wb.stat_out = STAT_AOK;
      WB_HALT: wb.stat_out = STAT_HLT;
      default: wb.stat_out = err_stat_q;
    endcase
  end

  assign wb.halted  = (state_q != WB_RUN);
  assign wb.retired = retired_q;
  assign wb.W_icode = w_icode_q;
  assign wb.W_dstE  = w_dstE_q;
  assign wb.W_dstM  = w_dstM_q;
  assign wb.W_valE  = w_valE_q;
  assign wb.W_valM  = w_valM_q;
  assign wb.W_stat  = w_stat_q;

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed + randomized bench for the writeback stage,
// checked against an instruction-level model of the architectural state.
module tb_writeback;
  import y86_pkg::*;

  logic clock = 1'b0;
  logic reset;

  writeback_if #(.CNT_W(64)) wb ();

  writeback #(.NREG(15), .CNT_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the instruction sitting in W, whether it has already
  // been acted on, the architectural registers, status and count.
  logic        mw_valid, mw_done;
  logic [2:0]  mw_stat;
  logic [3:0]  mw_icode, mw_dstE, mw_dstM;
  logic [63:0] mw_valE, mw_valM;
  logic [63:0] mregs [15];
  bit          m_running;
  logic [2:0]  mstat_out;
  logic [63:0] mret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mw_valid = 0; mw_done = 0; mw_stat = 3'd1; mw_icode = 4'd1;
    mw_dstE = 4'd15; mw_dstM = 4'd15; mw_valE = 0; mw_valM = 0;
    for (int i = 0; i < 15; i++) mregs[i] = 0;
    m_running = 1; mstat_out = 3'd1; mret = 0;
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] a);
    return (a == 4'd15) ? 64'd0 : mregs[a];
  endfunction

  task automatic model_edge();
    if (!m_running) return;
    if (mw_valid && !mw_done) begin
      if (mw_stat == 3'd1) begin
        if (mw_dstE != 4'd15) mregs[mw_dstE] = mw_valE;
        if (mw_dstM != 4'd15) mregs[mw_dstM] = mw_valM;
        mret = mret + 1;
      end else if (mw_stat == 3'd2) begin
        m_running = 0; mstat_out = 3'd2;
      end else begin
        m_running = 0; mstat_out = (mw_stat == 3'd3) ? 3'd3 : 3'd4;
      end
    end
    if (wb.w_stall) begin
      mw_done = 1;
    end else if (wb.w_bubble) begin
      mw_valid = 0; mw_done = 0; mw_stat = 3'd1; mw_icode = 4'd1;
      mw_dstE = 4'd15; mw_dstM = 4'd15; mw_valE = 0; mw_valM = 0;
    end else begin
      mw_valid = wb.m_valid; mw_done = 0; mw_stat = wb.m_stat;
      mw_icode = wb.m_icode; mw_dstE = wb.m_dstE; mw_dstM = wb.m_dstM;
      mw_valE = wb.m_valE; mw_valM = wb.m_valM;
    end
  endtask

  task automatic check_all(input string ph);
    wb.srcA = 4'($urandom_range(0, 15));
    wb.srcB = 4'($urandom_range(0, 15));
    #1;
    chk({ph, " W_icode"}, 64'(wb.W_icode), 64'(mw_icode));
    chk({ph, " W_dstE"},  64'(wb.W_dstE),  64'(mw_dstE));
    chk({ph, " W_dstM"},  64'(wb.W_dstM),  64'(mw_dstM));
    chk({ph, " W_valE"},  wb.W_valE, mw_valE);
    chk({ph, " W_valM"},  wb.W_valM, mw_valM);
    chk({ph, " W_stat"},  64'(wb.W_stat),  64'(mw_stat));
    chk({ph, " stat_out"}, 64'(wb.stat_out), 64'(mstat_out));
    chk({ph, " halted"},  64'(wb.halted), 64'(!m_running));
    chk({ph, " retired"}, wb.retired, mret);
    chk({ph, " valA"}, wb.valA, model_read(wb.srcA));
    chk({ph, " valB"}, wb.valB, model_read(wb.srcB));
  endtask

  task automatic step(input string ph);
    @(posedge clock);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic stall, input logic bub);
    wb.m_valid = v; wb.m_stat = st; wb.m_icode = ic;
    wb.m_dstE = de; wb.m_valE = ve; wb.m_dstM = dm; wb.m_valM = vm;
    wb.w_stall = stall; wb.w_bubble = bub;
  endtask

  task automatic idle();
    drive(0, STAT_AOK, I_NOP, RNONE, 0, RNONE, 0, 0, 0);
  endtask

  task automatic read_reg(input string tag, input logic [3:0] r, input logic [63:0] exp);
    wb.srcA = r;
    #1;
    chk(tag, wb.valA, exp);
  endtask

  task automatic mid_reset(input string ph);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(ph);
    for (int i = 0; i < 15; i++) read_reg({ph, " reg clear"}, 4'(i), 64'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    reset = 1'b1;
    idle();
    wb.srcA = 0; wb.srcB = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    check_all("reset");
    reset = 1'b0;
    #2;

    // irmovq $0x1234, %rdx
    drive(1, STAT_AOK, I_IRMOVQ, 4'd2, 64'h1234, RNONE, 0, 0, 0);
    step("irmovq1");
    idle();
    step("irmovq2");
    read_reg("irmovq valA", 4'd2, 64'h1234);
    chk("irmovq retired", wb.retired, 64'd1);

    // popq %rsp: both destinations are R4, valM must land
    drive(1, STAT_AOK, I_POPQ, RRSP, 64'h100, RRSP, 64'hBEEF, 0, 0);
    step("popq1");
    idle();
    step("popq2");
    read_reg("popq R4", RRSP, 64'hBEEF);

    // stall (with bubble) held three cycles
    drive(1, STAT_AOK, I_OPQ, 4'd5, 64'h55, RNONE, 0, 0, 0);
    step("stall load");
    drive(1, STAT_AOK, I_OPQ, 4'd5, 64'h99, 4'd6, 64'h77, 1, 1);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall W_icode", 64'(wb.W_icode), 64'(I_OPQ));
    chk("stall retired", wb.retired, 64'd3);
    read_reg("stall R5", 4'd5, 64'h55);
    read_reg("stall R6", 4'd6, 64'd0);
    drive(1, STAT_AOK, I_OPQ, 4'd5, 64'h99, 4'd6, 64'h77, 0, 1);
    step("bubble1");
    chk("bubble W_icode", 64'(wb.W_icode), 64'(I_NOP));
    idle();
    step("bubble2");
    chk("bubble retired", wb.retired, 64'd3);
    read_reg("bubble R6", 4'd6, 64'd0);

    // randomized AOK traffic
    for (int i = 0; i < 300; i++) begin
      r = {$urandom, $urandom};
      drive(($urandom_range(0, 4) != 0), STAT_AOK, 4'($urandom),
            4'($urandom), r, 4'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      step("random");
    end
    idle();
    step("random drain");

    // halt: the halting instruction and everything after it write nothing
    drive(1, STAT_AOK, I_IRMOVQ, 4'd3, 64'h33, RNONE, 0, 0, 0);
    step("pre-halt");
    drive(1, STAT_HLT, I_HALT, 4'd3, 64'd7, RNONE, 0, 0, 0);
    step("halt load");
    drive(1, STAT_AOK, I_IRMOVQ, 4'd3, 64'd9, RNONE, 0, 0, 0);
    step("halt");
    chk("halt halted", 64'(wb.halted), 64'd1);
    chk("halt stat_out", 64'(wb.stat_out), 64'(STAT_HLT));
    for (int i = 0; i < 4; i++) step("halted");
    read_reg("halt R3", 4'd3, 64'h33);

    mid_reset("reset after halt");

    // address error after a write, then mid-cycle reset
    drive(1, STAT_AOK, I_IRMOVQ, 4'd6, 64'h66, RNONE, 0, 0, 0);
    step("pre-err");
    drive(1, STAT_ADR, I_MRMOVQ, 4'd7, 64'h1, 4'd7, 64'h2, 0, 0);
    step("err load");
    idle();
    step("err");
    chk("err stat_out", 64'(wb.stat_out), 64'(STAT_ADR));
    read_reg("err R7", 4'd7, 64'd0);
    read_reg("err R6", 4'd6, 64'h66);
    step("err hold");

    mid_reset("reset after err");

    // undefined status code reports as INS
    drive(1, 3'd6, I_OPQ, 4'd1, 64'h5, RNONE, 0, 0, 0);
    step("ins load");
    idle();
    step("ins");
    chk("ins stat_out", 64'(wb.stat_out), 64'(STAT_INS));

    mid_reset("final reset");
    step("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
